// File: rtl/time_keeper_pkg.sv
// clock_pkg: shared mode encoding and time moduli for the wall-clock path.
package clock_pkg;
  typedef enum logic [1:0] {RUN, SET_HH, SET_MM} mode_t;
  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
endpackage

// File: rtl/time_keeper_if.sv
// time_keeper_if: tick/button inputs and time/mode outputs of the time keeper.
interface time_keeper_if;
  import clock_pkg::*;
  logic       tick_1s;
  logic       tick_500ms;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  mode_t      mode;
  logic       blink_on;
  logic       day_wrap;
  modport master (output tick_1s, tick_500ms, btn_mode, btn_inc,
                  input hours, minutes, seconds, mode, blink_on, day_wrap);
  modport slave  (input tick_1s, tick_500ms, btn_mode, btn_inc,
                  output hours, minutes, seconds, mode, blink_on, day_wrap);
endinterface

// File: rtl/time_keeper_mod_counter.sv
// mod_counter: wrapping modulo counter with a combinational carry-out on wrap.
module mod_counter #(
  parameter int MOD     = 60,
  parameter int W       = 6,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         carry
);
  logic [W-1:0] value_q, value_d;
  always_comb value_d = inc ? ((value_q == W'(MOD - 1)) ? '0 : value_q + 1'b1) : value_q;
  always_ff @(posedge clk)
    if (!rst_n) value_q <= W'(RST_VAL);
    else        value_q <= value_d;
  assign value = value_q;
  assign carry = inc && (value_q == W'(MOD - 1));
endmodule

// File: rtl/time_keeper.sv
// time_keeper: HH:MM:SS wall clock driven by divider ticks, with button-driven
// hour/minute setting and a blink enable for the field being edited.
module time_keeper
  import clock_pkg::*;
#(
  parameter int HOUR_MOD   = 24,
  parameter int RESET_HOUR = 0
) (
  input logic         clk,
  input logic         rst_n,
  time_keeper_if.slave tk
);
  mode_t mode_q, mode_d;
  logic  blink_q, blink_d;
  logic  day_wrap_q, day_wrap_d;
  logic  run, set_hh, set_mm, edit_inc, sec_clr;
  logic  sec_inc, min_inc, hr_inc, sec_c, min_c, hr_c;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  assign run      = mode_q == RUN;
  assign set_hh   = mode_q == SET_HH;
  assign set_mm   = mode_q == SET_MM;
  assign edit_inc = tk.btn_inc && !tk.btn_mode;
  // Leaving SET_MM restarts the minute cleanly; the seconds counter's sync reset does the clear.
  assign sec_clr  = set_mm && tk.btn_mode;
  assign sec_inc  = run && tk.tick_1s;
  assign min_inc  = run ? sec_c : set_mm && edit_inc;
  assign hr_inc   = run ? min_c : set_hh && edit_inc;
  mod_counter #(.MOD(SEC_MOD), .W(6), .RST_VAL(0)) u_sec (
    .clk(clk), .rst_n(rst_n && !sec_clr), .inc(sec_inc), .value(seconds), .carry(sec_c));
  mod_counter #(.MOD(MIN_MOD), .W(6), .RST_VAL(0)) u_min (
    .clk(clk), .rst_n(rst_n), .inc(min_inc), .value(minutes), .carry(min_c));
  mod_counter #(.MOD(HOUR_MOD), .W(5), .RST_VAL(RESET_HOUR)) u_hr (
    .clk(clk), .rst_n(rst_n), .inc(hr_inc), .value(hours), .carry(hr_c));
  always_comb begin
    mode_d = mode_q;
    if (!(run || set_hh || set_mm)) mode_d = RUN;
    else if (tk.btn_mode)           mode_d = run ? SET_HH : set_hh ? SET_MM : RUN;
    blink_d    = (tk.btn_mode || !(set_hh || set_mm)) ? 1'b1 : blink_q ^ tk.tick_500ms;
    day_wrap_d = run && hr_c;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      mode_q     <= RUN;
      blink_q    <= 1'b1;
      day_wrap_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      blink_q    <= blink_d;
      day_wrap_q <= day_wrap_d;
    end
  assign tk.hours    = hours;
  assign tk.minutes  = minutes;
  assign tk.seconds  = seconds;
  assign tk.mode     = mode_q;
  assign tk.blink_on = blink_q;
  assign tk.day_wrap = day_wrap_q;
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed and random stimulus on 24h and 12h instances,
// checked every cycle against a seconds-of-day reference model.
module tb_time_keeper;
  import clock_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  time_keeper_if b24();
  time_keeper_if b12();
  time_keeper #(.HOUR_MOD(24), .RESET_HOUR(0)) dut24 (.clk(clk), .rst_n(rst_n), .tk(b24.slave));
  time_keeper #(.HOUR_MOD(12), .RESET_HOUR(0)) dut12 (.clk(clk), .rst_n(rst_n), .tk(b12.slave));
  int passed = 0;
  int total  = 0;
  int hm[2] = '{24, 12};
  int hh[2], mm[2], ss[2], md[2];
  bit bl[2], dw[2];
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic model(int k, bit t1, bit t5, bit bm, bit bi, bit rn);
    int t;
    if (!rn) begin
      hh[k] = 0; mm[k] = 0; ss[k] = 0; md[k] = 0; bl[k] = 1; dw[k] = 0;
      return;
    end
    dw[k] = 0;
    if (md[k] == 0 && t1) begin
      t = hh[k] * 3600 + mm[k] * 60 + ss[k] + 1;
      if (t == hm[k] * 3600) begin
        t = 0;
        dw[k] = 1;
      end
      hh[k] = t / 3600;
      mm[k] = (t / 60) % 60;
      ss[k] = t % 60;
    end
    if (md[k] == 1 && bi && !bm) hh[k] = (hh[k] + 1) % hm[k];
    if (md[k] == 2 && bi && !bm) mm[k] = (mm[k] + 1) % 60;
    if (md[k] == 2 && bm) ss[k] = 0;
    if (bm) begin
      md[k] = (md[k] + 1) % 3;
      bl[k] = 1;
    end else if (md[k] != 0 && t5) bl[k] = !bl[k];
  endtask
  task automatic step(bit t1, bit t5, bit bm, bit bi, bit rn);
    rst_n = rn;
    b24.tick_1s = t1; b24.tick_500ms = t5; b24.btn_mode = bm; b24.btn_inc = bi;
    b12.tick_1s = t1; b12.tick_500ms = t5; b12.btn_mode = bm; b12.btn_inc = bi;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model(k, t1, t5, bm, bi, rn);
    check("h24.hours",    b24.hours,    hh[0]);
    check("h24.minutes",  b24.minutes,  mm[0]);
    check("h24.seconds",  b24.seconds,  ss[0]);
    check("h24.mode",     b24.mode,     md[0]);
    check("h24.blink_on", b24.blink_on, bl[0]);
    check("h24.day_wrap", b24.day_wrap, dw[0]);
    check("h12.hours",    b12.hours,    hh[1]);
    check("h12.minutes",  b12.minutes,  mm[1]);
    check("h12.seconds",  b12.seconds,  ss[1]);
    check("h12.mode",     b12.mode,     md[1]);
    check("h12.blink_on", b12.blink_on, bl[1]);
    check("h12.day_wrap", b12.day_wrap, dw[1]);
  endtask
  task automatic ticks(int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 1);
  endtask
  task automatic incs(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 1);
  endtask
  task automatic press_mode();
    step(0, 0, 1, 0, 1);
  endtask
  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("reset.hours", b24.hours, 0);
    check("reset.blink", b24.blink_on, 1);
    ticks(60);
    check("t1.minutes", b24.minutes, 1);
    check("t1.seconds", b24.seconds, 0);
    // Set 23:59 (11:59 on the 12h unit), return to RUN, run up to the day boundary.
    press_mode();
    incs(23);
    press_mode();
    incs(58);
    press_mode();
    check("t4.mode_run", b24.mode, RUN);
    ticks(59);
    check("t2.pre_h24", b24.hours, 23);
    check("t2.pre_h12", b12.hours, 11);
    ticks(1);
    check("t2.wrap24", b24.day_wrap, 1);
    check("t2.wrap12", b12.day_wrap, 1);
    check("t2.secs", b24.seconds, 0);
    step(0, 0, 0, 0, 1);
    check("t2.wrap_once", b24.day_wrap, 0);
    press_mode();
    incs(23);
    step(1, 1, 0, 0, 1);
    incs(2);
    check("t3.hours", b24.hours, 1);
    step(0, 0, 1, 1, 1);
    check("t4.mode_mm", b24.mode, SET_MM);
    incs(59);
    check("t4.min59", b24.minutes, 59);
    step(1, 0, 0, 1, 1);
    check("t4.min0", b24.minutes, 0);
    check("t4.hours", b24.hours, 1);
    step(1, 1, 1, 0, 1);
    check("t4.sec_clr", b24.seconds, 0);
    press_mode();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 1);
    check("t5.blink", b24.blink_on, 1);
    check("t5.hours", b24.hours, 1);
    press_mode();
    press_mode();
    incs(11);
    press_mode();
    incs(34);
    press_mode();
    ticks(56);
    check("t6.hours", b24.hours, 12);
    press_mode();
    press_mode();
    step(1, 1, 0, 1, 0);
    check("t6.rst_mode", b24.mode, RUN);
    check("t6.rst_sec", b24.seconds, 0);
    for (int i = 0; i < 2500; i++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 499) != 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
